// File: rtl/id_stage_v3.sv
// rtl/id_stage_v3.sv - MIPS decode stage: register file, sign extension, load-use hazard, ID/EX register, HI/LO
module id_stage_v3 #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32,
  parameter int CTRL_W   = 32,
  parameter int CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              iValid,
  input  logic [31:0]       Instruction,
  input  logic [DATA_W-1:0] PCPlus4,
  input  logic [CTRL_W-1:0] iCtrl,
  input  logic              iMemRead,
  input  logic              iUsesRt,
  input  logic              iExStall,
  input  logic              iFlush,
  input  logic              WBRegWrite,
  input  logic [REG_AW-1:0] WBAddr,
  input  logic [DATA_W-1:0] WBData,
  input  logic              HiLoWrite,
  input  logic [DATA_W-1:0] Hi,
  input  logic [DATA_W-1:0] Lo,
  output logic              oStallIF,
  output logic              oValid,
  output logic [CTRL_W-1:0] oCtrl,
  output logic              oMemRead,
  output logic [DATA_W-1:0] oPCPlus4,
  output logic [DATA_W-1:0] oReadReg1,
  output logic [DATA_W-1:0] oReadReg2,
  output logic [DATA_W-1:0] oSEImm,
  output logic [DATA_W-1:0] oSEImm2,
  output logic [REG_AW-1:0] oRs,
  output logic [REG_AW-1:0] oRt,
  output logic [REG_AW-1:0] oRd,
  output logic [DATA_W-1:0] oHi,
  output logic [DATA_W-1:0] oLo,
  output logic [CNT_W-1:0]  oStallCount
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rd1, rd2, se16, se26;
  logic              hazard, wb_en, unused_opcode;

  assign rs            = REG_AW'(Instruction[25:21]);
  assign rt            = REG_AW'(Instruction[20:16]);
  assign rd            = REG_AW'(Instruction[15:11]);
  assign unused_opcode = ^Instruction[31:26];
  assign se16          = DATA_W'($signed(Instruction[15:0]));
  assign se26          = DATA_W'($signed(Instruction[25:0]));
  assign wb_en         = WBRegWrite && (WBAddr != '0) && (32'(WBAddr) < NUM_REGS);

  // Same-cycle write-back is forwarded so the decode read never sees a stale value.
  function automatic logic [DATA_W-1:0] rf_read(input logic [REG_AW-1:0] a);
    if (a == '0 || 32'(a) >= NUM_REGS) return '0;
    if (WBRegWrite && WBAddr == a) return WBData;
    return regs[a];
  endfunction

  assign rd1 = rf_read(rs);
  assign rd2 = rf_read(rt);

  assign hazard   = iValid && oValid && oMemRead && (oRt != '0) &&
                    ((oRt == rs) || (iUsesRt && (oRt == rt)));
  assign oStallIF = !iFlush && (hazard || iExStall);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[WBAddr] <= WBData;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      oValid      <= 1'b0;
      oCtrl       <= '0;
      oMemRead    <= 1'b0;
      oPCPlus4    <= '0;
      oReadReg1   <= '0;
      oReadReg2   <= '0;
      oSEImm      <= '0;
      oSEImm2     <= '0;
      oRs         <= '0;
      oRt         <= '0;
      oRd         <= '0;
      oHi         <= '0;
      oLo         <= '0;
      oStallCount <= '0;
    end else begin
      if (HiLoWrite) begin
        oHi <= Hi;
        oLo <= Lo;
      end
      if (hazard && !iFlush && !iExStall && oStallCount != '1)
        oStallCount <= oStallCount + CNT_W'(1);
      // Flush overrides the downstream stall; a stall holds every field.
      if (iFlush || !iExStall) begin
        oPCPlus4  <= PCPlus4;
        oReadReg1 <= rd1;
        oReadReg2 <= rd2;
        oSEImm    <= se16;
        oSEImm2   <= se26;
        oRs       <= rs;
        oRt       <= rt;
        oRd       <= rd;
        if (iFlush || hazard) begin
          oValid   <= 1'b0;
          oCtrl    <= '0;
          oMemRead <= 1'b0;
        end else begin
          oValid   <= iValid;
          oCtrl    <= iValid ? iCtrl : '0;
          oMemRead <= iValid && iMemRead;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_stage_v3.sv
// tb/tb_id_stage_v3.sv - scoreboard bench for id_stage_v3
module tb_id_stage_v3;

  typedef struct packed {
    logic        valid;
    logic        memread;
    logic [31:0] ctrl;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] se;
    logic [31:0] se2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idex_t;

  logic        Clk = 1'b0, Reset = 1'b1;
  logic        iValid, iMemRead, iUsesRt, iExStall, iFlush, WBRegWrite, HiLoWrite;
  logic [31:0] Instruction, PCPlus4, iCtrl, WBData, Hi, Lo;
  logic [4:0]  WBAddr;

  logic        oStallIF, oValid, oMemRead;
  logic [31:0] oCtrl, oPCPlus4, oReadReg1, oReadReg2, oSEImm, oSEImm2, oHi, oLo;
  logic [4:0]  oRs, oRt, oRd;
  logic [15:0] oStallCount;

  logic        s_stall, s_valid, s_memread;
  logic [31:0] s_ctrl, s_pc, s_r1, s_r2, s_se, s_se2, s_hi, s_lo;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [1:0]  s_cnt;

  idex_t       obs, e, last_exp;
  idex_t       sb[$];
  logic [31:0] mregs [32];
  int          tests = 0, fails = 0, exp_cnt = 0, exp_s = 0;

  assign obs = {oValid, oMemRead, oCtrl, oPCPlus4, oReadReg1, oReadReg2, oSEImm, oSEImm2, oRs, oRt, oRd};

  always #5 Clk = ~Clk;

  id_stage_v3 dut (
    .Clk(Clk), .Reset(Reset), .iValid(iValid), .Instruction(Instruction), .PCPlus4(PCPlus4),
    .iCtrl(iCtrl), .iMemRead(iMemRead), .iUsesRt(iUsesRt), .iExStall(iExStall), .iFlush(iFlush),
    .WBRegWrite(WBRegWrite), .WBAddr(WBAddr), .WBData(WBData), .HiLoWrite(HiLoWrite), .Hi(Hi), .Lo(Lo),
    .oStallIF(oStallIF), .oValid(oValid), .oCtrl(oCtrl), .oMemRead(oMemRead), .oPCPlus4(oPCPlus4),
    .oReadReg1(oReadReg1), .oReadReg2(oReadReg2), .oSEImm(oSEImm), .oSEImm2(oSEImm2),
    .oRs(oRs), .oRt(oRt), .oRd(oRd), .oHi(oHi), .oLo(oLo), .oStallCount(oStallCount)
  );

  id_stage_v3 #(.CNT_W(2)) dut_s (
    .Clk(Clk), .Reset(Reset), .iValid(iValid), .Instruction(Instruction), .PCPlus4(PCPlus4),
    .iCtrl(iCtrl), .iMemRead(iMemRead), .iUsesRt(iUsesRt), .iExStall(iExStall), .iFlush(iFlush),
    .WBRegWrite(WBRegWrite), .WBAddr(WBAddr), .WBData(WBData), .HiLoWrite(HiLoWrite), .Hi(Hi), .Lo(Lo),
    .oStallIF(s_stall), .oValid(s_valid), .oCtrl(s_ctrl), .oMemRead(s_memread), .oPCPlus4(s_pc),
    .oReadReg1(s_r1), .oReadReg2(s_r2), .oSEImm(s_se), .oSEImm2(s_se2),
    .oRs(s_rs), .oRt(s_rt), .oRd(s_rd), .oHi(s_hi), .oLo(s_lo), .oStallCount(s_cnt)
  );

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (WBRegWrite && WBAddr == a) return WBData;
    return mregs[a];
  endfunction

  // live=0 models a bubble or flush: data loads, valid/ctrl/memread cleared.
  function automatic idex_t predict(input logic live);
    idex_t p;
    p.valid   = live & iValid;
    p.memread = live & iValid & iMemRead;
    p.ctrl    = (live & iValid) ? iCtrl : 32'd0;
    p.pc      = PCPlus4;
    p.r1      = mread(Instruction[25:21]);
    p.r2      = mread(Instruction[20:16]);
    p.se      = 32'($signed(Instruction[15:0]));
    p.se2     = 32'($signed(Instruction[25:0]));
    p.rs      = Instruction[25:21];
    p.rt      = Instruction[20:16];
    p.rd      = Instruction[15:11];
    return p;
  endfunction

  task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [10:0] fn, input logic mr, input logic ur, input logic [31:0] c);
    iValid      = v;
    Instruction = {6'h23, rs, rt, rd, fn};
    PCPlus4     = $urandom;
    iMemRead    = mr;
    iUsesRt     = ur;
    iCtrl       = c;
  endtask

  task automatic tick();
    @(posedge Clk);
    if (WBRegWrite && WBAddr != 5'd0) mregs[WBAddr] = WBData;
    if (HiLoWrite) begin end
    #1;
  endtask

  task automatic test_reset();
    iValid = 0; Instruction = 0; PCPlus4 = 0; iCtrl = 0; iMemRead = 0; iUsesRt = 0;
    iExStall = 0; iFlush = 0; WBRegWrite = 0; WBAddr = 0; WBData = 0; HiLoWrite = 0; Hi = 0; Lo = 0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    last_exp = '0;
    #12;
    tests++; if (obs !== idex_t'(0)) begin fails++; $display("FAIL reset_idex got %h exp 0", obs); end
    tests++; if ({oHi, oLo} !== 64'd0) begin fails++; $display("FAIL reset_hilo got %h/%h exp 0/0", oHi, oLo); end
    tests++; if (oStallCount !== 16'd0 || s_cnt !== 2'd0) begin fails++; $display("FAIL reset_cnt got %0d/%0d exp 0", oStallCount, s_cnt); end
    tests++; if (oStallIF !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", oStallIF); end
    Reset = 0;
  endtask

  task automatic test_bypass();
    WBRegWrite = 1; WBAddr = 5'd5; WBData = 32'hDEADBEEF;
    set_instr(1, 5'd5, 5'd0, 5'h1F, 11'h001, 0, 0, 32'hC0DE);
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    tests++; if (obs !== e) begin fails++; $display("FAIL bypass_idex got %h exp %h", obs, e); end
    tests++; if (oReadReg1 !== 32'hDEADBEEF) begin fails++; $display("FAIL bypass_r5 got %h exp deadbeef", oReadReg1); end
    tests++; if (oSEImm !== 32'hFFFFF801) begin fails++; $display("FAIL sext16 got %h exp fffff801", oSEImm); end
    WBAddr = 5'd0; WBData = 32'h55;
    set_instr(1, 5'd0, 5'd5, 5'h02, 11'h7FF, 0, 1, 32'hBEEF);
    Instruction[25:21] = 5'h10;
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    tests++; if (obs !== e) begin fails++; $display("FAIL r0_write_idex got %h exp %h", obs, e); end
    tests++; if (oSEImm2 !== 32'hFE0517FF) begin fails++; $display("FAIL sext26 got %h exp fe0517ff", oSEImm2); end
    WBRegWrite = 0;
    set_instr(1, 5'd0, 5'd5, 5'd0, 11'h0, 0, 0, 32'h7);
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    tests++; if (oReadReg1 !== 32'd0 || oReadReg2 !== 32'hDEADBEEF) begin fails++; $display("FAIL r0_reads_zero got %h/%h exp 0/deadbeef", oReadReg1, oReadReg2); end
  endtask

  task automatic test_load_use();
    set_instr(1, 5'd1, 5'd8, 5'd0, 11'h0, 1, 0, 32'h1);
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    tests++; if (obs !== e) begin fails++; $display("FAIL lw_issue got %h exp %h", obs, e); end
    set_instr(1, 5'd8, 5'd2, 5'd3, 11'h0, 0, 0, 32'h2); #1;
    tests++; if (oStallIF !== 1'b1) begin fails++; $display("FAIL lu_stall got %b exp 1", oStallIF); end
    sb.push_back(predict(0)); tick(); e = sb.pop_front(); last_exp = e; exp_cnt++;
    tests++; if (obs !== e) begin fails++; $display("FAIL lu_bubble got %h exp %h", obs, e); end
    tests++; if (oStallCount !== 16'(exp_cnt)) begin fails++; $display("FAIL lu_count got %0d exp %0d", oStallCount, exp_cnt); end
    tests++; if (oStallIF !== 1'b0) begin fails++; $display("FAIL lu_release got %b exp 0", oStallIF); end
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    tests++; if (obs !== e || oStallCount !== 16'(exp_cnt)) begin fails++; $display("FAIL lu_issue got %h cnt %0d exp %h cnt %0d", obs, oStallCount, e, exp_cnt); end
  endtask

  task automatic test_rt_dep();
    set_instr(1, 5'd1, 5'd8, 5'd0, 11'h0, 1, 0, 32'h3);
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    set_instr(1, 5'd3, 5'd8, 5'd4, 11'h0, 0, 0, 32'h4); #1;
    tests++; if (oStallIF !== 1'b0) begin fails++; $display("FAIL rt_unused_stall got %b exp 0", oStallIF); end
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    tests++; if (obs !== e) begin fails++; $display("FAIL rt_unused_issue got %h exp %h", obs, e); end
    set_instr(1, 5'd1, 5'd8, 5'd0, 11'h0, 1, 0, 32'h5);
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    set_instr(1, 5'd3, 5'd8, 5'd4, 11'h0, 0, 1, 32'h6); #1;
    tests++; if (oStallIF !== 1'b1) begin fails++; $display("FAIL rt_used_stall got %b exp 1", oStallIF); end
    sb.push_back(predict(0)); tick(); e = sb.pop_front(); last_exp = e; exp_cnt++;
    tests++; if (obs !== e || oStallCount !== 16'(exp_cnt)) begin fails++; $display("FAIL rt_used_bubble got %h cnt %0d exp %h cnt %0d", obs, oStallCount, e, exp_cnt); end
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    set_instr(1, 5'd1, 5'd0, 5'd0, 11'h0, 1, 0, 32'h7);
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    set_instr(1, 5'd0, 5'd0, 5'd4, 11'h0, 0, 1, 32'h8); #1;
    tests++; if (oStallIF !== 1'b0) begin fails++; $display("FAIL rt0_load_stall got %b exp 0", oStallIF); end
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    tests++; if (obs !== e || oStallCount !== 16'(exp_cnt)) begin fails++; $display("FAIL rt0_issue got %h cnt %0d exp %h cnt %0d", obs, oStallCount, e, exp_cnt); end
  endtask

  task automatic test_stall_flush();
    set_instr(1, 5'd2, 5'd9, 5'd1, 11'h0, 1, 0, 32'hAA);
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    set_instr(1, 5'd9, 5'd3, 5'd5, 11'h123, 0, 0, 32'hBB);
    iExStall = 1; HiLoWrite = 1; Hi = 32'h12; Lo = 32'h34;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (oStallIF !== 1'b1) begin fails++; $display("FAIL exstall_if cycle %0d got %b exp 1", c, oStallIF); end
      sb.push_back(last_exp); tick(); e = sb.pop_front();
      tests++; if (obs !== e || oStallCount !== 16'(exp_cnt)) begin fails++; $display("FAIL exstall_hold cycle %0d got %h cnt %0d exp %h cnt %0d", c, obs, oStallCount, e, exp_cnt); end
      tests++; if (oHi !== 32'h12 || oLo !== 32'h34) begin fails++; $display("FAIL hilo cycle %0d got %h/%h exp 12/34", c, oHi, oLo); end
      HiLoWrite = 0; Hi = 32'h99; Lo = 32'h98;
    end
    iFlush = 1; #1;
    tests++; if (oStallIF !== 1'b0) begin fails++; $display("FAIL flush_stall_if got %b exp 0", oStallIF); end
    sb.push_back(predict(0)); tick(); e = sb.pop_front(); last_exp = e;
    tests++; if (obs !== e || oStallCount !== 16'(exp_cnt)) begin fails++; $display("FAIL flush_over_stall got %h cnt %0d exp %h cnt %0d", obs, oStallCount, e, exp_cnt); end
    iFlush = 0; iExStall = 0;
  endtask

  task automatic test_async_reset();
    set_instr(1, 5'd1, 5'd8, 5'd0, 11'h0, 1, 0, 32'hCC);
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    set_instr(1, 5'd5, 5'd8, 5'd6, 11'h0, 0, 1, 32'hDD); #1;
    tests++; if (oStallIF !== 1'b1) begin fails++; $display("FAIL prereset_stall got %b exp 1", oStallIF); end
    #1 Reset = 1; #1;
    tests++; if (obs !== idex_t'(0) || {oHi, oLo} !== 64'd0) begin fails++; $display("FAIL async_reset got %h hi %h lo %h exp 0", obs, oHi, oLo); end
    tests++; if (oStallCount !== 16'd0 || s_cnt !== 2'd0 || oStallIF !== 1'b0) begin fails++; $display("FAIL async_reset_cnt got %0d/%0d stall %b exp 0/0/0", oStallCount, s_cnt, oStallIF); end
    #1 Reset = 0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    exp_cnt = 0;
    sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
    tests++; if (obs !== e || oReadReg1 !== 32'd0) begin fails++; $display("FAIL post_reset_issue got %h exp %h", obs, e); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) begin
      set_instr(1, 5'd1, 5'd8, 5'd0, 11'h0, 1, 0, 32'h10 + k);
      sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
      set_instr(1, 5'd8, 5'd2, 5'd3, 11'h0, 0, 0, 32'h20 + k);
      sb.push_back(predict(0)); tick(); e = sb.pop_front(); last_exp = e;
      exp_cnt++; exp_s = (exp_cnt > 3) ? 3 : exp_cnt;
      tests++; if (obs !== e) begin fails++; $display("FAIL sat_bubble %0d got %h exp %h", k, obs, e); end
      tests++; if (oStallCount !== 16'(exp_cnt) || s_cnt !== 2'(exp_s)) begin fails++; $display("FAIL sat_count %0d got %0d/%0d exp %0d/%0d", k, oStallCount, s_cnt, exp_cnt, exp_s); end
      sb.push_back(predict(1)); tick(); e = sb.pop_front(); last_exp = e;
      tests++; if (obs !== e) begin fails++; $display("FAIL sat_issue %0d got %h exp %h", k, obs, e); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_rt_dep();
    test_stall_flush();
    test_async_reset();
    test_saturation();
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_drain got %0d exp 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage_v3.md
Name: id_stage_v3

Overview:
- Parametrised next-generation decode stage for the 5-stage MIPS pipeline.
- Contains:
  - NUM_REGS-entry register file with write-through bypass.
  - 16- and 26-bit sign extension.
  - Load-use hazard detection with bubble insertion.
  - ID/EX pipeline register with valid bit, external stall and flush.
  - Architectural HI/LO registers.
  - Saturating load-use stall counter.
- Controller is external: its decoded control word arrives as an opaque CTRL_W bundle and is pipelined unchanged.

Parameters:
- DATA_W, 32, datapath width. Must be >= 26.
- REG_AW, 5, register address width.
- NUM_REGS, 32, register file depth (<= 2**REG_AW).
- CTRL_W, 32, width of the opaque control bundle.
- CNT_W, 16, stall counter width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- iValid  in  1  IF/ID holds a real instruction.
- Instruction  in  32  IF/ID instruction.
- PCPlus4  in  DATA_W  IF/ID PC+4.
- iCtrl  in  CTRL_W  controller output for Instruction.
- iMemRead  in  1  Instruction is a load.
- iUsesRt  in  1  Instruction reads rt as a source.
- iExStall  in  1  downstream stall: hold ID/EX.
- iFlush  in  1  squash the instruction entering ID/EX (taken branch/jump).
- WBRegWrite  in  1  write-back enable.
- WBAddr  in  REG_AW  write-back register.
- WBData  in  DATA_W  write-back data.
- HiLoWrite  in  1  update HI/LO.
- Hi  in  DATA_W  new HI.
- Lo  in  DATA_W  new LO.
- oStallIF  out  1  hold PC and IF/ID.
- oValid  out  1  ID/EX valid.
- oCtrl  out  CTRL_W  registered control.
- oMemRead  out  1  registered iMemRead.
- oPCPlus4  out  DATA_W  registered.
- oReadReg1  out  DATA_W  registered.
- oReadReg2  out  DATA_W  registered.
- oSEImm  out  DATA_W  registered.
- oSEImm2  out  DATA_W  registered.
- oRs  out  REG_AW  registered Instruction[25:21].
- oRt  out  REG_AW  registered Instruction[20:16].
- oRd  out  REG_AW  registered Instruction[15:11].
- oHi  out  DATA_W  architectural HI.
- oLo  out  DATA_W  architectural LO.
- oStallCount  out  CNT_W  load-use stall cycles.

Behaviour:
- Reset (async, active-high): all registered outputs, all register-file entries, HI/LO and the counter go to 0.
- Register file:
  - Write on rising Clk when WBRegWrite && WBAddr != 0 && WBAddr < NUM_REGS.
  - Entry 0 always reads 0.
  - Reads are combinational on rs/rt.
  - Bypass: when WBRegWrite && WBAddr == read address && address != 0, the read returns WBData in the same cycle.
  - Addresses >= NUM_REGS read 0.
- Sign extension:
  - oSEImm source = Instruction[15:0] sign-extended to DATA_W.
  - oSEImm2 source = Instruction[25:0] sign-extended to DATA_W.
- Hazard, combinational:
  - hazard = iValid && oValid && oMemRead && oRt != 0 && (oRt == Instruction[25:21] || (iUsesRt && oRt == Instruction[20:16])).
- oStallIF = !iFlush && (hazard || iExStall).
- ID/EX update, priority order each rising edge:
  1. iFlush: oValid, oCtrl, oMemRead ← 0. Data fields load normally; they are don't-care but deterministic.
  2. iExStall: all ID/EX fields hold.
  3. hazard: bubble. oValid, oCtrl, oMemRead ← 0; data fields load. The IF/ID instruction is re-presented next cycle.
  4. Otherwise: all fields load. oValid ← iValid. oCtrl and oMemRead are loaded gated by iValid, i.e. 0 when !iValid.
- HI/LO:
  - On rising Clk, HiLoWrite loads Hi/Lo into oHi/oLo, independent of stall and flush.
  - Otherwise they hold.
  - Latency 1 cycle.
- oStallCount:
  - Increments by 1 on each edge where hazard && !iFlush && !iExStall.
  - Saturates at 2**CNT_W-1.
- Latency: every ID/EX field is 1 cycle from input to output.
- Reset mid-stall: all state cleared. oStallIF follows the now-cleared oValid, going to 0 combinationally unless iExStall.

Test Plan:
- Bypass: write r5=0xDEADBEEF on the same cycle that Instruction has rs=5 → oReadReg1=0xDEADBEEF next edge. A write to r0 → r0 still reads 0.
- Load-use: lw r8 in ID/EX (oMemRead=1, oRt=8); next instruction has rs=8 → oStallIF=1 for exactly 1 cycle, oValid=0 bubble, oStallCount 0→1. The instruction then issues with oValid=1.
- rt-only dependency: same load, consumer has rt=8:
  - iUsesRt=0 → no stall.
  - iUsesRt=1 → stall.
  - oRt=0 load → never stalls.
- Stall/flush priority: iExStall=1 for 3 cycles → outputs frozen, oStallIF=1, counter unchanged. iFlush with iExStall both 1 → oValid=0, oStallIF=0.
- HI/LO: HiLoWrite with Hi=0x12, Lo=0x34 during iExStall → oHi=0x12, oLo=0x34 after 1 edge.
- Async reset asserted mid-cycle → all outputs 0 before next edge. Counter preset near max (CNT_W=2): four hazards → saturates at 3.
